dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter sharing the single-port synchronous data memory between the pipelined RISC-V core's memory stage and a DMA/loader port. CPU has default priority; a wait counter guarantees DMA forward progress by forcing a DMA grant after `MAX_WAIT` consecutive denied cycles. The arbiter:

- drives the memory-side `MemWrite`/`DataAdr`/`WriteData` signals;
- stalls the CPU when it loses arbitration;
- routes 1-cycle-latency read data back to the owning requester.

## Interface
- `DW`, 32: data width.
- `AW`, 32: address width.
- `MAX_WAIT`, 4: consecutive denied DMA cycles before DMA is forced (legal range 1..15).
- `clk`  in  1: clock; all state updates on rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `cpu_req`  in  1: CPU memory access request (M stage).
- `cpu_we`  in  1: CPU access is a write.
- `cpu_addr`  in  AW: CPU address.
- `cpu_wdata`  in  DW: CPU store data.
- `cpu_stall`  out  1: CPU denied this cycle; pipeline must hold.
- `cpu_rvalid`  out  1: `cpu_rdata` valid (read granted previous cycle).
- `cpu_rdata`  out  DW: CPU read data.
- `dma_req`  in  1: DMA request.
- `dma_we`  in  1: DMA access is a write.
- `dma_addr`  in  AW: DMA address.
- `dma_wdata`  in  DW: DMA write data.
- `dma_gnt`  out  1: DMA granted this cycle.
- `dma_rvalid`  out  1: `dma_rdata` valid.
- `dma_rdata`  out  DW: DMA read data.
- `MemWrite`  out  1: memory write enable.
- `DataAdr`  out  AW: memory address.
- `WriteData`  out  DW: memory write data.
- `ReadData`  in  DW: memory read data, valid the cycle after address presented.
- `stall_count`  out  32: saturating count of cycles with `cpu_stall`=1.

## Operation
- **Grant (combinational, per cycle):**
  - `force = (wait_cnt == MAX_WAIT)`.
  - `dma_gnt = dma_req & (~cpu_req | force)`.
  - `cpu_gnt = cpu_req & ~dma_gnt`.
  - `cpu_stall = cpu_req & ~cpu_gnt`.
- **Memory mux:**
  - Winner's addr/wdata drive `DataAdr`/`WriteData`.
  - `MemWrite = (cpu_gnt & cpu_we) | (dma_gnt & dma_we)`.
  - No grant: `DataAdr`/`WriteData` = 0, `MemWrite` = 0.
- **Wait counter (4-bit):**
  - Reset 0 on any cycle with `dma_gnt` = 1.
  - Reset 0 on any cycle with `dma_req` = 0.
  - Otherwise increments, saturating at `MAX_WAIT`.
- **Read owner register (2 bits: valid, owner):**
  - Set on the rising edge after a granted read (`we` = 0).
  - Cleared on the rising edge after a cycle with no granted read.
- **Read return:**
  - `cpu_rvalid` = owner valid & owner == CPU; `dma_rvalid` likewise for DMA.
  - `cpu_rdata` and `dma_rdata` are both `ReadData` passthrough; consumers qualify with their rvalid.
- **`stall_count`:** +1 each cycle `cpu_stall` = 1, saturates at 0xFFFF_FFFF.

## Timing
- Reset values:
  - `wait_cnt` = 0; owner register invalid.
  - `cpu_rvalid` = `dma_rvalid` = 0; `stall_count` = 0.
  - Combinational outputs follow inputs; with no requests, all outputs are 0.
- Grant latency 0: a request is granted, and the memory is driven, in the same cycle it is asserted.
- Write latency: committed at the rising edge ending the grant cycle.
- Read latency: rvalid exactly 1 cycle after the grant cycle.
- Back-to-back reads from alternating owners deliver data every cycle, each to the correct owner.
- Requesters hold req/addr/we/wdata stable until granted. The arbiter has no request buffering.
- Boundaries:
  - Both idle: no memory activity; `wait_cnt` stays 0.
  - Contention with `force` = 1: DMA wins; CPU stalls exactly that one cycle; `wait_cnt` returns to 0.
  - DMA drops req while waiting: `wait_cnt` clears; no grant issued.
  - `reset_n` low mid-read: owner register cleared asynchronously; no rvalid pulses after reset release for the aborted read.
  - `stall_count` at max: holds.

## Test plan
- **Solo CPU store:** `cpu_req`=1, `we`=1, addr 100, data 25 → same cycle `MemWrite`=1, `DataAdr`=100, `WriteData`=25, `cpu_stall`=0.
- **Solo DMA read:** addr 96, memory returns 0xDEADBEEF → `dma_gnt`=1 in cycle N; `dma_rvalid`=1, `dma_rdata`=0xDEADBEEF in cycle N+1; `cpu_rvalid`=0.
- **Continuous contention, `MAX_WAIT`=4:**
  - CPU granted cycles 0–3; DMA granted cycle 4; `cpu_stall` high only in cycle 4.
  - Pattern repeats every 5 cycles; `stall_count` = 2 after 10 cycles.
- **Alternating reads:** CPU read addr 0 in cycle N, DMA read addr 4 in cycle N+1 → cycle N+1 `cpu_rvalid`=1, cycle N+2 `dma_rvalid`=1; never both in one cycle.
- **DMA withdraw:** DMA waits 3 cycles, drops req 1 cycle, re-requests → counter restarts; DMA forced only after 4 further denied cycles.
- **Async reset:** `reset_n` low mid-cycle right after a granted read → `cpu_rvalid`/`dma_rvalid` = 0 immediately; `stall_count` = 0; no rvalid pulse after release.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - bundled CPU, DMA and memory-side signals of the data memory arbiter
interface dmem_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic          dma_rvalid;
  logic [DW-1:0] dma_rdata;

  logic          MemWrite;
  logic [AW-1:0] DataAdr;
  logic [DW-1:0] WriteData;
  logic [DW-1:0] ReadData;

  logic [31:0]   stall_count;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output MemWrite, DataAdr, WriteData,
    input  ReadData,
    output stall_count
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  MemWrite, DataAdr, WriteData,
    output ReadData,
    input  stall_count
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU-priority data memory arbiter with DMA starvation guard
module dmem_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  dmem_arbiter_if.slave bus
);
  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  logic [3:0]  r_wait_cnt;
  logic        r_rd_valid;
  logic        r_rd_dma;
  logic [31:0] r_stall_count;

  logic        w_force;
  logic        w_dma_gnt;
  logic        w_cpu_gnt;
  logic        w_cpu_stall;
  logic        w_rd_gnt;
  logic        w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata;

  // CPU wins by default; DMA wins when CPU is idle or DMA has waited MAX_WAIT cycles
  always_comb begin
    w_force     = (r_wait_cnt == LP_MAX_WAIT);
    w_dma_gnt   = bus.dma_req & (~bus.cpu_req | w_force);
    w_cpu_gnt   = bus.cpu_req & ~w_dma_gnt;
    w_cpu_stall = bus.cpu_req & ~w_cpu_gnt;
    w_rd_gnt    = (w_cpu_gnt & ~bus.cpu_we) | (w_dma_gnt & ~bus.dma_we);
  end

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (w_cpu_gnt) begin
      w_mem_we    = bus.cpu_we;
      w_mem_addr  = bus.cpu_addr;
      w_mem_wdata = bus.cpu_wdata;
    end else if (w_dma_gnt) begin
      w_mem_we    = bus.dma_we;
      w_mem_addr  = bus.dma_addr;
      w_mem_wdata = bus.dma_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= 4'd0;
    end else if (w_dma_gnt || !bus.dma_req) begin
      r_wait_cnt <= 4'd0;
    end else if (r_wait_cnt != LP_MAX_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  // Remembers who owns the read data returning from memory next cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_valid <= 1'b0;
      r_rd_dma   <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_gnt;
      r_rd_dma   <= w_dma_gnt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_count <= 32'd0;
    end else if (w_cpu_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign bus.cpu_stall   = w_cpu_stall;
  assign bus.dma_gnt     = w_dma_gnt;
  assign bus.MemWrite    = w_mem_we;
  assign bus.DataAdr     = w_mem_addr;
  assign bus.WriteData   = w_mem_wdata;
  assign bus.cpu_rvalid  = r_rd_valid & ~r_rd_dma;
  assign bus.dma_rvalid  = r_rd_valid & r_rd_dma;
  assign bus.cpu_rdata   = bus.ReadData;
  assign bus.dma_rdata   = bus.ReadData;
  assign bus.stall_count = r_stall_count;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter against a behavioural model
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MAX_WAIT = 4;

  logic clk;
  logic reset_n;

  dmem_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  dmem_arbiter #(.DW(DW), .AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous memory seen by the arbiter
  logic [DW-1:0] mem [64];
  logic [DW-1:0] r_rd;
  always @(posedge clk) begin
    if (bus.MemWrite) mem[bus.DataAdr[7:2]] <= bus.WriteData;
    r_rd <= mem[bus.DataAdr[7:2]];
  end
  assign bus.ReadData = r_rd;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int          m_wait;
  bit          m_rd_pend;
  bit          m_rd_dma;
  logic [31:0] m_rd_data;
  longint      m_stall;
  logic [31:0] shadow [64];
  bit          m_written [64];

  bit e_dg, e_cg;

  task automatic model_reset();
    m_wait = 0;
    m_rd_pend = 0;
    m_rd_dma = 0;
    m_rd_data = '0;
    m_stall = 0;
  endtask

  task automatic drive(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                       input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dd);
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.dma_req = dr; bus.dma_we = dw; bus.dma_addr = da; bus.dma_wdata = dd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Mid-cycle: compare every output against the model's view of this cycle
  task automatic settle();
    logic [31:0] ea, ed;
    bit ew;
    #3;
    e_dg = bus.dma_req && (!bus.cpu_req || m_wait == MAX_WAIT);
    e_cg = bus.cpu_req && !e_dg;
    ea = e_cg ? bus.cpu_addr : (e_dg ? bus.dma_addr : 32'd0);
    ed = e_cg ? bus.cpu_wdata : (e_dg ? bus.dma_wdata : 32'd0);
    ew = (e_cg && bus.cpu_we) || (e_dg && bus.dma_we);
    check("dma_gnt", bus.dma_gnt, e_dg);
    check("cpu_stall", bus.cpu_stall, bus.cpu_req && !e_cg);
    check("MemWrite", bus.MemWrite, ew);
    check("DataAdr", bus.DataAdr, ea);
    check("WriteData", bus.WriteData, ed);
    check("cpu_rvalid", bus.cpu_rvalid, m_rd_pend && !m_rd_dma);
    check("dma_rvalid", bus.dma_rvalid, m_rd_pend && m_rd_dma);
    if (m_rd_pend && !m_rd_dma) check("cpu_rdata", bus.cpu_rdata, m_rd_data);
    if (m_rd_pend && m_rd_dma)  check("dma_rdata", bus.dma_rdata, m_rd_data);
    check("stall_count", bus.stall_count, m_stall);
  endtask

  task automatic advance();
    logic [5:0] idx;
    idx = e_cg ? bus.cpu_addr[7:2] : bus.dma_addr[7:2];
    if (e_dg || !bus.dma_req) m_wait = 0;
    else if (m_wait < MAX_WAIT) m_wait++;
    m_rd_pend = (e_cg && !bus.cpu_we) || (e_dg && !bus.dma_we);
    m_rd_dma = e_dg;
    m_rd_data = (m_written[idx]) ? shadow[idx] : 32'hx;
    if (m_rd_pend && !m_written[idx]) m_rd_pend = m_rd_pend; // data unknown; only valid bit compared
    if ((e_cg && bus.cpu_we) || (e_dg && bus.dma_we)) begin
      shadow[idx] = e_cg ? bus.cpu_wdata : bus.dma_wdata;
      m_written[idx] = 1;
    end
    if (bus.cpu_req && !e_cg && m_stall < 64'hFFFF_FFFF) m_stall++;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  bit          cr, cw, dr, dw;
  logic [31:0] ca, cd, da, dd;
  longint      s0;
  bit          wd_req [9] = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
  bit          wd_gnt [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    for (int i = 0; i < 64; i++) m_written[i] = 0;
    reset_n = 0;
    idle();
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    check("rst_dma_rvalid", bus.dma_rvalid, 0);
    check("rst_stall_count", bus.stall_count, 0);
    check("rst_memwrite", bus.MemWrite, 0);
    check("rst_dataadr", bus.DataAdr, 0);
    reset_n = 1;
    cycle();

    // Prime every memory word so every read has a known value
    for (int i = 0; i < 64; i++) begin
      drive(0, 0, 0, 0, 1, 1, 32'(i * 4), $urandom);
      cycle();
    end

    // Solo CPU store
    drive(1, 1, 100, 25, 0, 0, 0, 0);
    settle();
    check("st_memwrite", bus.MemWrite, 1);
    check("st_dataadr", bus.DataAdr, 100);
    check("st_wdata", bus.WriteData, 25);
    check("st_stall", bus.cpu_stall, 0);
    advance();

    // Solo DMA read of 0xDEADBEEF
    drive(0, 0, 0, 0, 1, 1, 96, 32'hDEADBEEF);
    cycle();
    drive(0, 0, 0, 0, 1, 0, 96, 0);
    settle();
    check("dr_gnt", bus.dma_gnt, 1);
    advance();
    idle();
    settle();
    check("dr_rvalid", bus.dma_rvalid, 1);
    check("dr_rdata", bus.dma_rdata, 32'hDEADBEEF);
    check("dr_cpu_rvalid", bus.cpu_rvalid, 0);
    advance();

    // Continuous contention: DMA forced every fifth cycle
    idle();
    cycle();
    s0 = m_stall;
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 32'(i * 4), 0, 1, 1, 200, 32'h1234_0000 + 32'(i));
      settle();
      check("ct_dma_gnt", bus.dma_gnt, (i % 5) == 4);
      check("ct_stall", bus.cpu_stall, (i % 5) == 4);
      advance();
    end
    check("ct_stall_count", bus.stall_count, s0 + 2);

    // Alternating-owner reads
    idle();
    cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 1, 0, 4, 0);
    settle();
    check("alt_cpu_rvalid", bus.cpu_rvalid, 1);
    check("alt_dma_rvalid0", bus.dma_rvalid, 0);
    advance();
    idle();
    settle();
    check("alt_dma_rvalid", bus.dma_rvalid, 1);
    check("alt_cpu_rvalid0", bus.cpu_rvalid, 0);
    advance();

    // DMA withdraw restarts the wait count
    idle();
    cycle();
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 8, 0, wd_req[i], 0, 12, 0);
      settle();
      check("wd_dma_gnt", bus.dma_gnt, wd_gnt[i]);
      advance();
    end

    // Randomized traffic; stalled requesters hold their request
    idle();
    cr = 0; dr = 0;
    cw = 0; dw = 0; ca = 0; cd = 0; da = 0; dd = 0;
    for (int n = 0; n < 600; n++) begin
      if (!cr || e_cg) begin
        cr = ($urandom_range(0, 3) != 0);
        cw = $urandom_range(0, 1);
        ca = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        cd = $urandom;
      end
      if (!dr || e_dg || ($urandom_range(0, 9) == 0)) begin
        dr = ($urandom_range(0, 2) != 0);
        dw = $urandom_range(0, 1);
        da = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        dd = $urandom;
      end
      drive(cr, cw, ca, cd, dr, dw, da, dd);
      settle();
      advance();
    end

    // Asynchronous reset right after a granted read
    drive(1, 0, 16, 0, 0, 0, 0, 0);
    cycle();
    check("ar_pending", bus.cpu_rvalid, 1);
    #1;
    reset_n = 0;
    idle();
    #1;
    check("ar_cpu_rvalid", bus.cpu_rvalid, 0);
    check("ar_dma_rvalid", bus.dma_rvalid, 0);
    check("ar_stall_count", bus.stall_count, 0);
    model_reset();
    @(posedge clk); #2;
    reset_n = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("ar_no_rvalid", bus.cpu_rvalid | bus.dma_rvalid, 0);
      advance();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
